// File: rtl/matmul_tile_sequencer.sv
// Sequences an M x N x (K_TILES*ARRAY_SIZE) matmul: one A/B read pair per cycle, tag-aligned
// accumulation of adder-tree sums across K tiles, one clamped output word per element.
module matmul_tile_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int DIM_W      = 6,
  parameter int ADDR_W     = 12,
  parameter int PIPE_LAT   = 8,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_W-1:0]      cfg_m,
  input  logic [DIM_W-1:0]      cfg_n,
  input  logic [DIM_W-1:0]      cfg_k_tiles,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  en_a,
  output logic                  en_b,
  output logic [ADDR_W-1:0]     addr_a,
  output logic [ADDR_W-1:0]     addr_b,
  input  logic [DATA_WIDTH-1:0] tree_result,
  output logic                  en_out,
  output logic                  we_out,
  output logic [ADDR_W-1:0]     addr_out,
  output logic [DATA_WIDTH-1:0] dout_out
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              vld;
    logic              first;
    logic              last;
    logic [ADDR_W-1:0] oaddr;
  } tag_t;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  state_t state, state_nxt;

  logic [DIM_W-1:0]  m_q, n_q, k_q, i_q, j_q, t_q;
  logic [ADDR_W-1:0] a_base, addr_a_q, addr_b_q, oaddr_q;
  logic              cfg_zero, accept, t_end, j_end, i_end, pipe_busy;

  tag_t tag_in, tag_out;
  tag_t pipe [PIPE_LAT];

  logic signed [ACC_WIDTH-1:0] acc, acc_nxt, tr_ext;
  logic [DATA_WIDTH-1:0]       wr_dat;

  assign cfg_zero = (cfg_m == '0) || (cfg_n == '0) || (cfg_k_tiles == '0);
  assign accept   = (state == IDLE) && start;
  assign t_end    = (t_q == k_q - 1'b1);
  assign j_end    = (j_q == n_q - 1'b1);
  assign i_end    = (i_q == m_q - 1'b1);

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign en_a   = (state == RUN);
  assign en_b   = en_a;
  assign addr_a = addr_a_q;
  assign addr_b = addr_b_q;
  assign we_out = en_out;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = cfg_zero ? DONE : RUN;
      RUN:     if (t_end && j_end && i_end) state_nxt = DRAIN;
      DRAIN:   if (!pipe_busy) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Loop counters; addresses advance by increments only (A rewinds to row base, B/out run on).
  always_ff @(posedge clk) begin
    if (rst) begin
      {m_q, n_q, k_q, i_q, j_q, t_q} <= '0;
      {a_base, addr_a_q, addr_b_q, oaddr_q} <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= accept && cfg_zero;
      if (accept) begin
        m_q <= cfg_m;
        n_q <= cfg_n;
        k_q <= cfg_k_tiles;
        {i_q, j_q, t_q} <= '0;
        {a_base, addr_a_q, addr_b_q, oaddr_q} <= '0;
      end else if (state == RUN) begin
        if (!t_end) begin
          t_q      <= t_q + 1'b1;
          addr_a_q <= addr_a_q + 1'b1;
          addr_b_q <= addr_b_q + 1'b1;
        end else begin
          t_q     <= '0;
          oaddr_q <= oaddr_q + 1'b1;
          if (!j_end) begin
            j_q      <= j_q + 1'b1;
            addr_a_q <= a_base;
            addr_b_q <= addr_b_q + 1'b1;
          end else begin
            j_q      <= '0;
            i_q      <= i_q + 1'b1;
            a_base   <= addr_a_q + 1'b1;
            addr_a_q <= addr_a_q + 1'b1;
            addr_b_q <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    tag_in.vld   = (state == RUN);
    tag_in.first = (t_q == '0);
    tag_in.last  = t_end;
    tag_in.oaddr = oaddr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < PIPE_LAT; s++) pipe[s] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int s = 1; s < PIPE_LAT; s++) pipe[s] <= pipe[s-1];
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int s = 0; s < PIPE_LAT; s++) pipe_busy = pipe_busy | pipe[s].vld;
  end

  assign tag_out = pipe[PIPE_LAT-1];
  assign tr_ext  = ACC_WIDTH'($signed(tree_result));
  assign acc_nxt = tag_out.first ? tr_ext : acc + tr_ext;

  always_comb begin
    wr_dat = acc_nxt[DATA_WIDTH-1:0];
    if (SATURATE) begin
      if (acc_nxt > SAT_MAX)      wr_dat = SAT_MAX[DATA_WIDTH-1:0];
      else if (acc_nxt < SAT_MIN) wr_dat = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  // Output word is registered from the same acc_nxt that updates the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      en_out   <= 1'b0;
      addr_out <= '0;
      dout_out <= '0;
    end else begin
      if (tag_out.vld) acc <= acc_nxt;
      en_out <= tag_out.vld && tag_out.last;
      if (tag_out.vld && tag_out.last) begin
        addr_out <= tag_out.oaddr;
        dout_out <= wr_dat;
      end
    end
  end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench: a saturating and a wrapping instance share stimulus; a delay line models memory + tree.
module tb_matmul_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  cfg_m, cfg_n, cfg_k_tiles;
  logic [15:0] tree_result;
  logic [15:0] tr_val;
  logic [7:0]  sh = '0;

  logic        busy, done, cfg_err, en_a, en_b, en_out, we_out;
  logic [11:0] addr_a, addr_b, addr_out;
  logic [15:0] dout_out;

  logic        busy_w, done_w, cfg_err_w, en_a_w, en_b_w, en_out_w, we_out_w;
  logic [11:0] addr_a_w, addr_b_w, addr_out_w;
  logic [15:0] dout_out_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Result of a read issued in cycle c appears in cycle c+8; junk otherwise exposes misalignment.
  always @(posedge clk) sh <= {sh[6:0], en_a};
  assign tree_result = sh[7] ? tr_val : 16'h0BAD;

  matmul_tile_sequencer #(.SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_m(cfg_m), .cfg_n(cfg_n),
    .cfg_k_tiles(cfg_k_tiles), .busy(busy), .done(done), .cfg_err(cfg_err),
    .en_a(en_a), .en_b(en_b), .addr_a(addr_a), .addr_b(addr_b),
    .tree_result(tree_result), .en_out(en_out), .we_out(we_out),
    .addr_out(addr_out), .dout_out(dout_out)
  );

  matmul_tile_sequencer #(.SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .start(start), .cfg_m(cfg_m), .cfg_n(cfg_n),
    .cfg_k_tiles(cfg_k_tiles), .busy(busy_w), .done(done_w), .cfg_err(cfg_err_w),
    .en_a(en_a_w), .en_b(en_b_w), .addr_a(addr_a_w), .addr_b(addr_b_w),
    .tree_result(tree_result), .en_out(en_out_w), .we_out(we_out_w),
    .addr_out(addr_out_w), .dout_out(dout_out_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one job and checks every cycle from the first issue to the return to idle.
  task automatic run_job(input int m, input int n, input int k, input logic [15:0] val,
                         input logic [15:0] exp_sat, input logic [15:0] exp_wrap,
                         input bit repulse);
    int total, ii, jj, tt, w;
    bit exp_wr;
    total = m * n * k;
    cfg_m = 6'(m); cfg_n = 6'(n); cfg_k_tiles = 6'(k);
    tr_val = val;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc <= total + 10; cyc++) begin
      chk("en_a", en_a, 32'(cyc < total));
      chk("en_b", en_b, 32'(cyc < total));
      if (cyc < total) begin
        ii = cyc / (n * k);
        jj = (cyc / k) % n;
        tt = cyc % k;
        chk("addr_a", addr_a, ii * k + tt);
        chk("addr_b", addr_b, jj * k + tt);
      end
      exp_wr = (cyc >= 8 + k) && ((cyc - 8) % k == 0) && ((cyc - 8) / k <= m * n);
      chk("en_out", en_out, 32'(exp_wr));
      chk("we_out", we_out, 32'(exp_wr));
      chk("en_out_wrap", en_out_w, 32'(exp_wr));
      if (exp_wr) begin
        w = (cyc - 8) / k - 1;
        chk("addr_out", addr_out, w);
        chk("dout_sat", dout_out, 32'(exp_sat));
        chk("dout_wrap", dout_out_w, 32'(exp_wrap));
      end
      chk("done", done, 32'(cyc == total + 9));
      chk("busy", busy, 32'(cyc <= total + 9));
      chk("cfg_err", cfg_err, 32'h0);
      if (repulse && cyc == 2) begin
        start = 1'b1;
        cfg_m = 6'd1; cfg_n = 6'd1; cfg_k_tiles = 6'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tr_val = '0;
    cfg_m = '0; cfg_n = '0; cfg_k_tiles = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 32'h0);
    chk("rst_done", done, 32'h0);
    chk("rst_en_a", en_a, 32'h0);
    chk("rst_en_out", en_out, 32'h0);
    chk("rst_dout", dout_out, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // T1: single element, done 11 cycles after start
    run_job(1, 1, 1, 16'd5, 16'd5, 16'd5, 1'b0);
    // T2: 2x3 outputs, K=4, each sum 4
    run_job(2, 3, 4, 16'd1, 16'd4, 16'd4, 1'b0);
    // T3: saturation high / low versus wrapping
    run_job(1, 1, 4, 16'h4000, 16'h7FFF, 16'h0000, 1'b0);
    run_job(1, 2, 4, 16'hC000, 16'h8000, 16'h0000, 1'b0);
    // negative sum inside range
    run_job(2, 1, 2, 16'hFFFD, 16'hFFFA, 16'hFFFA, 1'b0);
    // T5: start re-pulsed mid-run is ignored
    run_job(2, 2, 3, 16'd7, 16'd21, 16'd21, 1'b1);

    // T4: zero dimension rejected
    cfg_m = 6'd2; cfg_n = 6'd0; cfg_k_tiles = 6'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rej_done", done, 32'h1);
    chk("rej_cfg_err", cfg_err, 32'h1);
    chk("rej_en_a", en_a, 32'h0);
    @(negedge clk);
    chk("rej_done_end", done, 32'h0);
    chk("rej_cfg_err_end", cfg_err, 32'h0);
    chk("rej_busy_end", busy, 32'h0);
    for (int c = 0; c < 10; c++) begin
      chk("rej_en_a_idle", en_a, 32'h0);
      chk("rej_en_out_idle", en_out, 32'h0);
      @(negedge clk);
    end

    // T6: reset during a 4x4x4 job
    cfg_m = 6'd4; cfg_n = 6'd4; cfg_k_tiles = 6'd4; tr_val = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_en_a", en_a, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 32'h0);
    chk("abort_done", done, 32'h0);
    chk("abort_cfg_err", cfg_err, 32'h0);
    chk("abort_en_a", en_a, 32'h0);
    chk("abort_en_b", en_b, 32'h0);
    chk("abort_addr_a", addr_a, 32'h0);
    chk("abort_addr_b", addr_b, 32'h0);
    chk("abort_en_out", en_out, 32'h0);
    chk("abort_we_out", we_out, 32'h0);
    chk("abort_addr_out", addr_out, 32'h0);
    chk("abort_dout", dout_out, 32'h0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("abort_no_done", done, 32'h0);
      chk("abort_no_write", en_out, 32'h0);
    end
    run_job(1, 1, 1, 16'd5, 16'd5, 16'd5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
